// File: rtl/vga_sync_decoder_if.sv
// Pin-side and decoded-timing signals of the VGA receive path.
// The source (renderer or bench) uses master; the decoder uses slave.
interface vga_sync_decoder_if;
    logic        hsync_in;
    logic        vsync_in;
    logic [2:0]  rgb_in;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        visible;
    logic [2:0]  rgb;
    logic        locked;
    logic [10:0] h_period;
    logic [10:0] v_lines;
    logic        frame_strobe;
    logic [18:0] frame_lit;

    modport master (
        output hsync_in, vsync_in, rgb_in,
        input  x, y, visible, rgb, locked, h_period, v_lines, frame_strobe, frame_lit
    );

    modport slave (
        input  hsync_in, vsync_in, rgb_in,
        output x, y, visible, rgb, locked, h_period, v_lines, frame_strobe, frame_lit
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// VGA receive front-end: synchronises raw sync/rgb pins, measures line and frame timing,
// locks onto a stable mode, regenerates pixel coordinates and counts lit pixels per frame.
module vga_sync_decoder #(
    parameter bit          SYNC_ACTIVE_LOW = 1'b1,
    parameter int unsigned H_VIS_START     = 144,
    parameter int unsigned H_VISIBLE       = 640,
    parameter int unsigned V_VIS_START     = 35,
    parameter int unsigned V_VISIBLE       = 480,
    parameter int unsigned LOCK_LINES      = 4
) (
    input  logic              clk,
    input  logic              reset,
    vga_sync_decoder_if.slave vga
);

    localparam int unsigned CW  = 11;
    localparam int unsigned CW1 = CW + 1;
    localparam int unsigned XW  = 10;
    localparam int unsigned LW  = 19;
    localparam int unsigned MW  = 4;
    localparam int unsigned MW1 = MW + 1;

    localparam logic [CW-1:0]  CNT_MAX   = '1;
    localparam logic [LW-1:0]  LIT_MAX   = '1;
    localparam logic           SYNC_IDLE = SYNC_ACTIVE_LOW;
    localparam logic [CW1-1:0] H_LO      = CW1'(H_VIS_START);
    localparam logic [CW1-1:0] H_HI      = CW1'(H_VIS_START + H_VISIBLE);
    localparam logic [CW1-1:0] V_LO      = CW1'(V_VIS_START);
    localparam logic [CW1-1:0] V_HI      = CW1'(V_VIS_START + V_VISIBLE);
    localparam logic [MW1-1:0] LOCK_N    = MW1'(LOCK_LINES);

    typedef enum logic [1:0] {
        SEARCH,
        HLOCK,
        LOCKED
    } state_e;

    // synchroniser and edge-detect registers
    logic          hs_meta_q, hs_sync_q, hs_act_q;
    logic          vs_meta_q, vs_sync_q, vs_act_q;
    logic [2:0]    rgb_meta_q, rgb_sync_q, rgb_dly_q;

    // timing measurement
    logic [CW-1:0] hcount_q, vcount_q;
    logic [CW-1:0] h_period_q, v_lines_q;
    logic          vs_armed_q;
    logic [LW-1:0] lit_q, frame_lit_q;
    logic          frame_strobe_q;

    // output stage
    logic [XW-1:0] x_q, y_q;
    logic          vis_q;
    logic [2:0]    rgb_q;

    // lock FSM
    state_e        state_q;
    logic [MW-1:0] match_cnt_q;
    logic          locked_q;

    // combinational next values
    logic           hs_act, vs_act, hs_edge, vs_edge;
    logic           frame_bnd, h_match, hcount_sat;
    logic [CW1-1:0] hcount_inc, vcount_inc;
    logic [CW-1:0]  h_len, v_len;
    logic [CW-1:0]  hcount_d, vcount_d;
    logic [CW-1:0]  h_off, v_off;
    logic           h_in, v_in, vis_d, vs_armed_d;
    logic [XW-1:0]  x_d, y_d;
    logic [LW-1:0]  lit_d;
    logic [MW1-1:0] match_inc;

    // two-flop synchronisers, then one register for edge detection on normalised sync
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_meta_q  <= SYNC_IDLE;
            hs_sync_q  <= SYNC_IDLE;
            vs_meta_q  <= SYNC_IDLE;
            vs_sync_q  <= SYNC_IDLE;
            rgb_meta_q <= '0;
            rgb_sync_q <= '0;
            hs_act_q   <= 1'b0;
            vs_act_q   <= 1'b0;
            rgb_dly_q  <= '0;
        end else begin
            hs_meta_q  <= vga.hsync_in;
            hs_sync_q  <= hs_meta_q;
            vs_meta_q  <= vga.vsync_in;
            vs_sync_q  <= vs_meta_q;
            rgb_meta_q <= vga.rgb_in;
            rgb_sync_q <= rgb_meta_q;
            hs_act_q   <= hs_act;
            vs_act_q   <= vs_act;
            rgb_dly_q  <= rgb_sync_q;
        end
    end

    always_comb begin
        hs_act     = hs_sync_q ^ SYNC_IDLE;
        vs_act     = vs_sync_q ^ SYNC_IDLE;
        hs_edge    = hs_act & ~hs_act_q;
        vs_edge    = vs_act & ~vs_act_q;

        // 12-bit increments so a saturated counter never aliases a real period
        hcount_inc = {1'b0, hcount_q} + CW1'(1);
        vcount_inc = {1'b0, vcount_q} + CW1'(1);
        h_len      = hcount_inc[CW] ? CNT_MAX : hcount_inc[CW-1:0];
        v_len      = vcount_inc[CW] ? CNT_MAX : vcount_inc[CW-1:0];
        h_match    = (hcount_inc == {1'b0, h_period_q});
        hcount_sat = (hcount_q == CNT_MAX);
        match_inc  = {1'b0, match_cnt_q} + MW1'(1);

        hcount_d   = hcount_sat ? CNT_MAX : hcount_inc[CW-1:0];
        if (hs_edge) begin
            hcount_d = '0;
        end

        // a pending vsync edge turns the next hsync edge into the frame boundary
        frame_bnd  = hs_edge & (vs_armed_q | vs_edge);
        vs_armed_d = frame_bnd ? 1'b0 : (vs_armed_q | vs_edge);

        vcount_d = vcount_q;
        if (frame_bnd) begin
            vcount_d = '0;
        end else if (hs_edge && !vcount_inc[CW]) begin
            vcount_d = vcount_inc[CW-1:0];
        end

        h_in  = ({1'b0, hcount_q} >= H_LO) && ({1'b0, hcount_q} < H_HI);
        v_in  = ({1'b0, vcount_q} >= V_LO) && ({1'b0, vcount_q} < V_HI);
        h_off = hcount_q - CW'(H_VIS_START);
        v_off = vcount_q - CW'(V_VIS_START);
        vis_d = locked_q & h_in & v_in;
        x_d   = vis_d ? XW'(h_off) : '0;
        y_d   = vis_d ? XW'(v_off) : '0;

        lit_d = lit_q;
        if (frame_bnd) begin
            lit_d = '0;
        end else if (vis_d && (rgb_dly_q != 3'b000) && (lit_q != LIT_MAX)) begin
            lit_d = lit_q + LW'(1);
        end
    end

    // counters, measurements and the registered output stage
    always_ff @(posedge clk) begin
        if (reset) begin
            hcount_q       <= '0;
            vcount_q       <= '0;
            h_period_q     <= '0;
            v_lines_q      <= '0;
            vs_armed_q     <= 1'b0;
            lit_q          <= '0;
            frame_lit_q    <= '0;
            frame_strobe_q <= 1'b0;
            x_q            <= '0;
            y_q            <= '0;
            vis_q          <= 1'b0;
            rgb_q          <= '0;
        end else begin
            hcount_q       <= hcount_d;
            vcount_q       <= vcount_d;
            vs_armed_q     <= vs_armed_d;
            lit_q          <= lit_d;
            frame_strobe_q <= frame_bnd;
            x_q            <= x_d;
            y_q            <= y_d;
            vis_q          <= vis_d;
            rgb_q          <= rgb_dly_q;
            if (hs_edge) begin
                h_period_q <= h_len;
            end
            if (frame_bnd) begin
                v_lines_q   <= v_len;
                frame_lit_q <= lit_q;
            end
        end
    end

    // lock FSM; a lost hsync (hcount saturation) overrides every state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SEARCH;
            match_cnt_q <= '0;
            locked_q    <= 1'b0;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (hs_edge) begin
                        if (h_match) begin
                            match_cnt_q <= MW'(match_inc);
                            if (match_inc >= LOCK_N) begin
                                state_q <= HLOCK;
                            end
                        end else begin
                            match_cnt_q <= '0;
                        end
                    end
                end
                HLOCK: begin
                    if (hs_edge && !h_match) begin
                        state_q     <= SEARCH;
                        match_cnt_q <= '0;
                    end else if (frame_bnd && (v_len == v_lines_q)) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                    end
                end
                LOCKED: begin
                    if ((hs_edge && !h_match) || (frame_bnd && (v_len != v_lines_q))) begin
                        state_q     <= SEARCH;
                        match_cnt_q <= '0;
                        locked_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= SEARCH;
                    match_cnt_q <= '0;
                    locked_q    <= 1'b0;
                end
            endcase
            if (hcount_sat) begin
                state_q     <= SEARCH;
                match_cnt_q <= '0;
                locked_q    <= 1'b0;
            end
        end
    end

    assign vga.x            = x_q;
    assign vga.y            = y_q;
    assign vga.visible      = vis_q;
    assign vga.rgb          = rgb_q;
    assign vga.locked       = locked_q;
    assign vga.h_period     = h_period_q;
    assign vga.v_lines      = v_lines_q;
    assign vga.frame_strobe = frame_strobe_q;
    assign vga.frame_lit    = frame_lit_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a reduced video mode (48 clk/line, 20 lines/frame)
// plus a second instance fed inverted syncs with SYNC_ACTIVE_LOW=0.
module tb_vga_sync_decoder;

    localparam int H_TOTAL = 48;
    localparam int H_SYNC  = 6;
    localparam int HVS     = 10;
    localparam int HV      = 32;
    localparam int V_TOTAL = 20;
    localparam int V_SYNC  = 2;
    localparam int VVS     = 4;
    localparam int VV      = 12;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vga_sync_decoder_if vga ();
    vga_sync_decoder_if vga2 ();

    vga_sync_decoder #(
        .SYNC_ACTIVE_LOW(1'b1), .H_VIS_START(HVS), .H_VISIBLE(HV),
        .V_VIS_START(VVS), .V_VISIBLE(VV), .LOCK_LINES(4)
    ) dut (
        .clk(clk), .reset(reset), .vga(vga)
    );

    vga_sync_decoder #(
        .SYNC_ACTIVE_LOW(1'b0), .H_VIS_START(HVS), .H_VISIBLE(HV),
        .V_VIS_START(VVS), .V_VISIBLE(VV), .LOCK_LINES(4)
    ) dut_hi (
        .clk(clk), .reset(reset), .vga(vga2)
    );

    int checks = 0;
    int errors = 0;

    // generator state: gen_* is the next position, cur_* the one currently on the pins
    bit gen_run = 0;
    bit short_req = 0, hold_req = 0;
    bit cur_short = 0, cur_hold = 0;
    int mode_req = 0, cur_mode = 0;
    int gen_h = 0, gen_v = 0, cur_h = -1, cur_v = -1, cur_len = H_TOTAL;

    initial begin
        logic hs_a, vs_a;
        logic [2:0] px;
        vga.hsync_in = 1'b1; vga.vsync_in = 1'b1; vga.rgb_in = '0;
        vga2.hsync_in = 1'b0; vga2.vsync_in = 1'b0; vga2.rgb_in = '0;
        forever begin
            @(negedge clk);
            if (gen_run) begin
                if (gen_h == 0) begin
                    cur_short = short_req;
                    cur_len   = short_req ? H_TOTAL - 1 : H_TOTAL;
                    cur_hold  = hold_req;
                    if (gen_v == 0) cur_mode = mode_req;
                end
                hs_a = (gen_h < H_SYNC) && !cur_hold;
                vs_a = (gen_v < V_SYNC);
                case (cur_mode)
                    1:       px = 3'b111;
                    2:       px = (gen_h == HVS + 5 && gen_v == VVS + 3) ? 3'b010 : 3'b000;
                    3:       px = 3'(gen_h);
                    default: px = 3'b000;
                endcase
                vga.hsync_in = ~hs_a; vga.vsync_in = ~vs_a; vga.rgb_in = px;
                vga2.hsync_in = hs_a; vga2.vsync_in = vs_a; vga2.rgb_in = px;
                cur_h = gen_h;
                cur_v = gen_v;
                if (gen_h == cur_len - 1) begin
                    gen_h = 0;
                    gen_v = (gen_v == V_TOTAL - 1) ? 0 : gen_v + 1;
                end else begin
                    gen_h++;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_strobe(input string tag);
        int n = 0;
        do begin tick(1); n++; end while (!vga.frame_strobe && n < 1500);
        check(tag, 32'(vga.frame_strobe), 1);
    endtask

    task automatic wait_locked(input string tag, input int budget);
        int n = 0;
        do begin tick(1); n++; end while (!vga.locked && n < budget);
        check(tag, 32'(vga.locked), 1);
    endtask

    task automatic frame_lit_after(input int mode, input int exp, input string tag);
        mode_req = mode;
        wait_strobe({tag, "_s1"});
        wait_strobe({tag, "_s2"});
        check(tag, 32'(vga.frame_lit), exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_x"}, 32'(vga.x), 0);
        check({tag, "_y"}, 32'(vga.y), 0);
        check({tag, "_visible"}, 32'(vga.visible), 0);
        check({tag, "_rgb"}, 32'(vga.rgb), 0);
        check({tag, "_locked"}, 32'(vga.locked), 0);
        check({tag, "_h_period"}, 32'(vga.h_period), 0);
        check({tag, "_v_lines"}, 32'(vga.v_lines), 0);
        check({tag, "_strobe"}, 32'(vga.frame_strobe), 0);
        check({tag, "_frame_lit"}, 32'(vga.frame_lit), 0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        tick(3);
        check_reset_outputs("rst");
        check("rst_locked_hi", 32'(vga2.locked), 0);
        @(negedge clk);
        reset = 1'b0;
        tick(1);
        gen_run = 1;

        // acquisition from reset: partial first frame, then two full frames
        wait_strobe("strobe1");
        check("v_lines_first", 32'(vga.v_lines), 1);
        check("locked_f1", 32'(vga.locked), 0);
        tick(1);
        check("strobe_one_cycle", 32'(vga.frame_strobe), 0);
        wait_strobe("strobe2");
        check("h_period", 32'(vga.h_period), H_TOTAL);
        check("v_lines", 32'(vga.v_lines), V_TOTAL);
        check("locked_f2", 32'(vga.locked), 0);
        wait_strobe("strobe3");
        check("locked_f3", 32'(vga.locked), 1);
        check("locked_f3_hi", 32'(vga2.locked), 1);

        // lit counting over whole frames
        frame_lit_after(1, HV * VV, "lit_white");
        check("lit_white_hi", 32'(vga2.frame_lit), HV * VV);
        frame_lit_after(0, 0, "lit_black");
        frame_lit_after(2, 1, "lit_single");
        frame_lit_after(3, 28 * VV, "lit_ramp");

        // visible window timing on line 6 (y=2) with rgb = column[2:0]
        n = 0;
        do begin tick(1); n++; end while (!(cur_h == 0 && cur_v == 6) && n < 1500);
        check("wait_line6", 32'(cur_h == 0 && cur_v == 6), 1);
        tick(HVS + 2);
        check("pre_window_vis", 32'(vga.visible), 0);
        tick(1);
        check("first_px_vis", 32'(vga.visible), 1);
        check("first_px_x", 32'(vga.x), 0);
        check("first_px_y", 32'(vga.y), 2);
        check("first_px_rgb", 32'(vga.rgb), 2);
        tick(HV - 1);
        check("last_px_vis", 32'(vga.visible), 1);
        check("last_px_x", 32'(vga.x), HV - 1);
        check("last_px_rgb", 32'(vga.rgb), 1);
        tick(1);
        check("post_window_vis", 32'(vga.visible), 0);
        check("post_window_x", 32'(vga.x), 0);

        // one short line drops lock right after its terminating hsync edge
        short_req = 1;
        n = 0;
        do begin tick(1); n++; end while (!cur_short && n < 200);
        short_req = 0;
        check("wait_short", 32'(cur_short), 1);
        n = 0;
        do begin tick(1); n++; end while (!(cur_h == 0 && !cur_short) && n < 200);
        check("wait_after_short", 32'(cur_h == 0 && !cur_short), 1);
        check("short_locked_k", 32'(vga.locked), 1);
        tick(1);
        check("short_locked_k1", 32'(vga.locked), 1);
        tick(1);
        check("short_locked_k2", 32'(vga.locked), 0);
        check("short_h_period", 32'(vga.h_period), H_TOTAL - 1);
        wait_locked("relock_short", 3000);
        check("relock_h_period", 32'(vga.h_period), H_TOTAL);

        // hsync loss saturates hcount and drops lock
        hold_req = 1;
        n = 0;
        do begin tick(1); n++; end while (!(cur_h == 0 && cur_hold) && n < 200);
        check("wait_hold", 32'(cur_h == 0 && cur_hold), 1);
        tick(2100);
        check("loss_locked", 32'(vga.locked), 0);
        check("loss_visible", 32'(vga.visible), 0);
        check("loss_h_period", 32'(vga.h_period), H_TOTAL);
        hold_req = 0;
        n = 0;
        do begin tick(1); n++; end while (!(cur_h == 0 && !cur_hold) && n < 200);
        check("wait_restore", 32'(cur_h == 0 && !cur_hold), 1);
        tick(2);
        check("sat_h_period", 32'(vga.h_period), 2047);
        wait_locked("relock_loss", 5000);

        // reset in the middle of a visible line
        n = 0;
        do begin tick(1); n++; end while (!vga.visible && n < 1500);
        check("wait_visible", 32'(vga.visible), 1);
        @(negedge clk);
        reset = 1'b1;
        tick(1);
        check_reset_outputs("midrst");
        tick(2);
        @(negedge clk);
        reset = 1'b0;
        wait_locked("relock_reset", 5000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
